bus_rx_capture: RTL and testbench
=================================

BUS_RX_CAPTURE -- requirements
Module: bus_rx_capture

Interface
REQ-001 SHALL have ports: sysclk  in  1  single system clock, all logic on rising edge.
REQ-002 SHALL have ports: sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: bus_d  in  10  shared bus data from a remote 10-bit latching driver.
REQ-004 SHALL have ports: bus_le  in  1  remote latch enable; high = transparent, falling = data frozen.
REQ-005 SHALL have ports: bus_oe_n  in  1  remote output enable, active-low; bus_d meaningful only when low.
REQ-006 SHALL have ports: rx_data  out  10  head-of-buffer word.
REQ-007 SHALL have ports: rx_valid  out  1  rx_data holds a word.
REQ-008 SHALL have ports: rx_ready  in  1  consumer accepts the word on the same edge when rx_valid=1.
REQ-009 SHALL have ports: rx_level  out  2  buffer occupancy, 0..2.
REQ-010 SHALL have ports: rx_ovf  out  1  sticky overflow flag.
REQ-011 SHALL have ports: ovf_clr  in  1  synchronous clear of rx_ovf.
REQ-012 SHALL have ports: abort_pulse  out  1  one-cycle pulse when a transfer aborts.

Function
REQ-013 SHALL run FSM IDLE, OPEN, PUSH with sampled (le, oe_n) values.
REQ-014 IDLE: le=1 and oe_n=0 -> OPEN; shadow register loads bus_d.
REQ-015 OPEN: le=1, oe_n=0 -> stay; shadow reloads bus_d every cycle.
REQ-016 OPEN: le=0, oe_n=0 -> PUSH; shadow holds the value of the last le-high cycle.
REQ-017 OPEN: oe_n=1 -> IDLE, abort_pulse=1 for one cycle, no push.
REQ-018 PUSH SHALL last one cycle, write shadow into the buffer, then -> IDLE.
REQ-019 PUSH with oe_n=1 in the same cycle SHALL still push.
REQ-020 Buffer SHALL be a 2-entry FIFO, first-in first-out.
REQ-021 rx_data and rx_valid SHALL be registered outputs.
REQ-022 A word pushed at edge N SHALL show rx_valid=1 from edge N+1 when the buffer was empty.
REQ-023 Pop SHALL occur when rx_valid and rx_ready are both 1; rx_ready with rx_valid=0 SHALL have no effect.
REQ-024 Push to a full buffer with a pop on the same edge SHALL succeed; rx_level stays 2.
REQ-025 Push to a full buffer without a pop SHALL drop the word and set rx_ovf; buffer contents SHALL be unchanged.
REQ-026 rx_ovf SHALL stay set until ovf_clr=1; ovf_clr and a new overflow on the same edge SHALL leave rx_ovf=1.
REQ-027 Pointer wrap: 1-bit read/write pointers plus a count; rx_level SHALL equal the count.

Reset
REQ-028 sys_rst_n low SHALL force: state IDLE; FIFO empty; rx_valid=0; rx_data=0; rx_level=0; rx_ovf=0; abort_pulse=0; shadow=0.
REQ-029 Reset asserted mid-transfer (OPEN or PUSH) SHALL discard the transfer.
REQ-030 After reset release, the first capture SHALL require a fresh le=1 with oe_n=0.

Configuration
REQ-031 Macro BUS_RX_SYNC_EN SHALL be the single compile option.
REQ-032 When BUS_RX_SYNC_EN is defined, bus_le and bus_oe_n SHALL pass through 2-flop synchronisers before the FSM.
REQ-033 With BUS_RX_SYNC_EN defined, bus_d SHALL be delayed 2 flops to stay aligned, all FSM latencies SHALL increase by 2 cycles, and synchroniser flops SHALL reset to le=0, oe_n=1.
REQ-034 When BUS_RX_SYNC_EN is not defined, the FSM SHALL sample the inputs directly.

Structure
REQ-035 Shared package nd_bus_pkg SHALL hold BUS_W=10, RX_DEPTH=2 and the FSM state enum (IDLE, OPEN, PUSH).
REQ-036 The FIFO SHALL be the sub-module bus_rx_fifo, carrying push, pop, data, level and full/empty; FSM and synchronisers SHALL stay in the top.

Verification
REQ-037 Test 1: oe_n=0, le=1 for 3 cycles with bus_d=0x155, 0x2AA, 0x3C3, then le=0 -> exactly one word 0x3C3 in the buffer, rx_valid high 1 cycle after PUSH.
REQ-038 Test 2: le=1 and oe_n=0 with bus_d=0x0F0, then oe_n=1 before le falls -> abort_pulse for one cycle, rx_level=0.
REQ-039 Test 3: rx_ready=0 and three transfers 0x001, 0x002, 0x003 -> rx_level=2, rx_ovf=1, pops return 0x001 then 0x002.
REQ-040 Test 4: buffer full and PUSH of 0x004 on the same edge as a pop -> rx_ovf stays 0, next pops return 0x002 then 0x004.
REQ-041 Test 5: sys_rst_n pulsed low while in OPEN -> all outputs 0, rx_level=0, the following transfer is captured normally.
REQ-042 Test 6: Tests 1 and 3 rerun with BUS_RX_SYNC_EN defined -> same data, every latency plus 2 cycles.

Source files
------------

// File: rtl/nd_bus_pkg.sv
// Shared constants and FSM state type for the remote-bus receive capture path.
package nd_bus_pkg;

    localparam int unsigned BUS_W    = 10;
    localparam int unsigned RX_DEPTH = 2;
    localparam int unsigned LVL_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        PUSH = 2'd2
    } rx_state_t;

endpackage

// File: rtl/bus_rx_fifo.sv
// Two-entry FIFO with 1-bit read/write pointers, an occupancy count and
// registered head-of-buffer data/valid outputs.
module bus_rx_fifo
    import nd_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [BUS_W-1:0] push_data,
    input  logic             pop,
    output logic [BUS_W-1:0] head_data,
    output logic             head_valid,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [BUS_W-1:0] mem [RX_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [LVL_W-1:0] count;

    logic             do_pop;
    logic             do_push;
    logic             rd_ptr_nxt;
    logic [LVL_W-1:0] count_nxt;
    logic [BUS_W-1:0] head_nxt;

    assign empty = (count == '0);
    assign full  = (count == LVL_W'(RX_DEPTH));
    assign level = count;

    // Head register is loaded with the word that will sit at rd_ptr after this
    // edge, bypassing mem when that slot is being written on the same edge.
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        rd_ptr_nxt = rd_ptr ^ do_pop;
        count_nxt  = count + LVL_W'(do_push) - LVL_W'(do_pop);
        head_nxt   = head_data;
        if (count_nxt != '0) begin
            if (do_push && (wr_ptr == rd_ptr_nxt))
                head_nxt = push_data;
            else
                head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= '0;
            head_data  <= '0;
            head_valid <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr ^ do_push;
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            head_data  <= head_nxt;
            head_valid <= (count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bus_rx_capture.sv
// Captures words from a remote latching bus driver into a 2-entry FIFO.
// Compile option BUS_RX_SYNC_EN adds 2-flop synchronisers on le/oe_n and d.
module bus_rx_capture
    import nd_bus_pkg::*;
(
    input  logic             sysclk,
    input  logic             sys_rst_n,
    input  logic [BUS_W-1:0] bus_d,
    input  logic             bus_le,
    input  logic             bus_oe_n,
    output logic [BUS_W-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [LVL_W-1:0] rx_level,
    output logic             rx_ovf,
    input  logic             ovf_clr,
    output logic             abort_pulse
);

    logic             le_s;
    logic             oe_n_s;
    logic [BUS_W-1:0] d_s;

`ifdef BUS_RX_SYNC_EN
    logic [1:0]       le_sync;
    logic [1:0]       oe_n_sync;
    logic [BUS_W-1:0] d_dly [2];

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            le_sync   <= '0;
            oe_n_sync <= '1;
            d_dly[0]  <= '0;
            d_dly[1]  <= '0;
        end else begin
            le_sync   <= {le_sync[0], bus_le};
            oe_n_sync <= {oe_n_sync[0], bus_oe_n};
            d_dly[0]  <= bus_d;
            d_dly[1]  <= d_dly[0];
        end
    end

    assign le_s   = le_sync[1];
    assign oe_n_s = oe_n_sync[1];
    assign d_s    = d_dly[1];
`else
    assign le_s   = bus_le;
    assign oe_n_s = bus_oe_n;
    assign d_s    = bus_d;
`endif

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             load_shadow;
    logic             push;
    logic             abort;
    logic [BUS_W-1:0] shadow;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (le_s && !oe_n_s) state_nxt = OPEN;
            OPEN: begin
                if (oe_n_s)
                    state_nxt = IDLE;
                else if (!le_s)
                    state_nxt = PUSH;
            end
            PUSH:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_shadow = 1'b0;
        push        = 1'b0;
        abort       = 1'b0;
        unique case (state)
            IDLE:    load_shadow = le_s && !oe_n_s;
            OPEN: begin
                load_shadow = le_s && !oe_n_s;
                abort       = oe_n_s;
            end
            PUSH:    push = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow      <= '0;
            abort_pulse <= 1'b0;
            rx_ovf      <= 1'b0;
        end else begin
            if (load_shadow)
                shadow <= d_s;
            abort_pulse <= abort;
            // A new overflow wins over a simultaneous clear.
            if (push && fifo_full && !pop)
                rx_ovf <= 1'b1;
            else if (ovf_clr)
                rx_ovf <= 1'b0;
        end
    end

    assign pop = rx_ready && !fifo_empty;

    bus_rx_fifo u_fifo (
        .clk        (sysclk),
        .rst_n      (sys_rst_n),
        .push       (push),
        .push_data  (shadow),
        .pop        (pop),
        .head_data  (rx_data),
        .head_valid (rx_valid),
        .level      (rx_level),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_bus_rx_capture.sv
// Self-checking bench for bus_rx_capture: vector table plus scoreboarded transfers.
// Define BUS_RX_SYNC_EN for both bench and RTL to check the synchronised build.
module tb_bus_rx_capture;

`ifdef BUS_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       sysclk = 1'b0;
    logic       sys_rst_n;
    logic [9:0] bus_d;
    logic       bus_le;
    logic       bus_oe_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [1:0] rx_level;
    logic       rx_ovf;
    logic       ovf_clr;
    logic       abort_pulse;

    bus_rx_capture dut (
        .sysclk      (sysclk),
        .sys_rst_n   (sys_rst_n),
        .bus_d       (bus_d),
        .bus_le      (bus_le),
        .bus_oe_n    (bus_oe_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_level    (rx_level),
        .rx_ovf      (rx_ovf),
        .ovf_clr     (ovf_clr),
        .abort_pulse (abort_pulse)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic       le;
        logic       oe_n;
        logic [9:0] d;
        logic       exp_valid;
        logic [1:0] exp_level;
        logic       exp_abort;
        logic [9:0] exp_data;
    } vec_t;

    vec_t       tbl [10];
    logic [9:0] sb_q [$];
    logic       ovf_exp;
    int         n_pass  = 0;
    int         n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive(input logic le, input logic oe_n, input logic [9:0] d);
        bus_le   = le;
        bus_oe_n = oe_n;
        bus_d    = d;
    endtask

    // Row k's expectation is checked LAT edges later than its stimulus.
    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi + LAT; i++) begin
            if (i <= hi)
                drive(tbl[i].le, tbl[i].oe_n, tbl[i].d);
            else
                drive(1'b0, 1'b1, 10'h000);
            step();
            if (i - LAT >= lo) begin
                int k;
                k = i - LAT;
                check($sformatf("row%0d_valid", k), 32'(rx_valid), 32'(tbl[k].exp_valid));
                check($sformatf("row%0d_level", k), 32'(rx_level), 32'(tbl[k].exp_level));
                check($sformatf("row%0d_abort", k), 32'(abort_pulse), 32'(tbl[k].exp_abort));
                if (tbl[k].exp_valid)
                    check($sformatf("row%0d_data", k), 32'(rx_data), 32'(tbl[k].exp_data));
            end
        end
    endtask

    // One full transfer; rdy/clr are asserted on the edge where the PUSH writes.
    task automatic xfer(input logic [9:0] w, input logic rdy, input logic clr);
        logic ovf_now;
        drive(1'b1, 1'b0, w);
        step();
        drive(1'b0, 1'b0, 10'h000);
        repeat (1 + LAT) step();
        drive(1'b0, 1'b1, 10'h000);
        rx_ready = rdy;
        ovf_clr  = clr;
        ovf_now  = 1'b0;
        if (rdy && sb_q.size() > 0) begin
            check("xfer_pop_valid", 32'(rx_valid), 32'(1'b1));
            check("xfer_pop_data", 32'(rx_data), 32'(sb_q.pop_front()));
        end
        if (sb_q.size() < 2)
            sb_q.push_back(w);
        else
            ovf_now = 1'b1;
        if (ovf_now)
            ovf_exp = 1'b1;
        else if (clr)
            ovf_exp = 1'b0;
        step();
        rx_ready = 1'b0;
        ovf_clr  = 1'b0;
        check($sformatf("xfer_%0h_level", w), 32'(rx_level), 32'(sb_q.size()));
        check($sformatf("xfer_%0h_ovf", w), 32'(rx_ovf), 32'(ovf_exp));
    endtask

    task automatic drain(input int n);
        rx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("drain_valid", 32'(rx_valid), 32'(1'b1));
            if (sb_q.size() > 0)
                check("drain_data", 32'(rx_data), 32'(sb_q.pop_front()));
            step();
        end
        rx_ready = 1'b0;
        check("drain_level", 32'(rx_level), 32'(sb_q.size()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          le    oe_n  d       valid level abort data
        tbl[0] = '{1'b1, 1'b0, 10'h155, 1'b0, 2'd0, 1'b0, 10'h000};
        tbl[1] = '{1'b1, 1'b0, 10'h2AA, 1'b0, 2'd0, 1'b0, 10'h000};
        tbl[2] = '{1'b1, 1'b0, 10'h3C3, 1'b0, 2'd0, 1'b0, 10'h000};
        tbl[3] = '{1'b0, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 10'h000};
        tbl[4] = '{1'b0, 1'b1, 10'h000, 1'b1, 2'd1, 1'b0, 10'h3C3};
        tbl[5] = '{1'b0, 1'b1, 10'h000, 1'b1, 2'd1, 1'b0, 10'h3C3};
        tbl[6] = '{1'b1, 1'b0, 10'h0F0, 1'b0, 2'd0, 1'b0, 10'h000};
        tbl[7] = '{1'b1, 1'b1, 10'h0F0, 1'b0, 2'd0, 1'b1, 10'h000};
        tbl[8] = '{1'b0, 1'b1, 10'h000, 1'b0, 2'd0, 1'b0, 10'h000};
        tbl[9] = '{1'b0, 1'b1, 10'h000, 1'b0, 2'd0, 1'b0, 10'h000};

        sys_rst_n = 1'b0;
        rx_ready  = 1'b0;
        ovf_clr   = 1'b0;
        ovf_exp   = 1'b0;
        drive(1'b0, 1'b1, 10'h000);
        repeat (3) step();
        check("rst_valid", 32'(rx_valid), 32'(1'b0));
        check("rst_data", 32'(rx_data), 32'(10'h000));
        check("rst_level", 32'(rx_level), 32'(2'd0));
        check("rst_ovf", 32'(rx_ovf), 32'(1'b0));
        check("rst_abort", 32'(abort_pulse), 32'(1'b0));
        sys_rst_n = 1'b1;
        repeat (3) step();

        // Test 1: last le-high value captured, valid one cycle after PUSH
        run_rows(0, 5);
        sb_q.push_back(10'h3C3);
        drain(1);

        // Test 2: oe_n rises while OPEN
        run_rows(6, 9);

        // Test 3: overflow with rx_ready low; clear on an overflow edge keeps flag
        xfer(10'h001, 1'b0, 1'b0);
        xfer(10'h002, 1'b0, 1'b0);
        xfer(10'h003, 1'b0, 1'b0);
        xfer(10'h005, 1'b0, 1'b1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        ovf_exp = 1'b0;
        check("ovf_clear", 32'(rx_ovf), 32'(ovf_exp));
        drain(2);

        // Test 4: push into a full buffer on the same edge as a pop
        xfer(10'h001, 1'b0, 1'b0);
        xfer(10'h002, 1'b0, 1'b0);
        xfer(10'h004, 1'b1, 1'b0);
        drain(2);

        // Test 5: reset while OPEN
        xfer(10'h2AA, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 10'h155);
        repeat (1 + LAT) step();
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(rx_valid), 32'(1'b0));
        check("midrst_data", 32'(rx_data), 32'(10'h000));
        check("midrst_level", 32'(rx_level), 32'(2'd0));
        check("midrst_ovf", 32'(rx_ovf), 32'(1'b0));
        check("midrst_abort", 32'(abort_pulse), 32'(1'b0));
        sb_q.delete();
        ovf_exp = 1'b0;
        drive(1'b0, 1'b1, 10'h000);
        repeat (2) step();
        sys_rst_n = 1'b1;
        repeat (2 + LAT) step();
        check("postrst_level", 32'(rx_level), 32'(2'd0));
        xfer(10'h0A5, 1'b0, 1'b0);
        drain(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
